// File: rtl/vm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vm_pkg                                                               |
// | Shared vending-machine types: payout state encoding, money width and |
// | default coin denominations.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vm_pkg;

    localparam int unsigned c_money_w  = 4;

    localparam int unsigned c_denom_hi  = 5;
    localparam int unsigned c_denom_mid = 2;
    localparam int unsigned c_denom_lo  = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PAY  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coin_select                                                          |
// | Picks the largest available denomination not exceeding the amount.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module coin_select
    import vm_pkg::*;
#(
    parameter int unsigned DENOM_HI  = c_denom_hi,
    parameter int unsigned DENOM_MID = c_denom_mid,
    parameter int unsigned DENOM_LO  = c_denom_lo
) (
    input  logic [c_money_w-1:0] amount,
    input  logic [2:0]           avail,     // {hi, mid, lo}
    output logic [c_money_w-1:0] coin,
    output logic                 found
);

    localparam logic [c_money_w-1:0] c_hi  = c_money_w'(DENOM_HI);
    localparam logic [c_money_w-1:0] c_mid = c_money_w'(DENOM_MID);
    localparam logic [c_money_w-1:0] c_lo  = c_money_w'(DENOM_LO);

    always_comb begin
        coin  = '0;
        found = 1'b0;
        if (avail[2] && amount >= c_hi) begin
            coin  = c_hi;
            found = 1'b1;
        end else if (avail[1] && amount >= c_mid) begin
            coin  = c_mid;
            found = 1'b1;
        end else if (avail[0] && amount >= c_lo && amount != '0) begin
            coin  = c_lo;
            found = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | change_dispenser                                                     |
// | Pays a balance out as single coins, largest first, over valid/ready. |
// | Optional macro CHANGE_STOCK_EN adds per-denomination stock counters. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned DENOM_HI   = c_denom_hi,
    parameter int unsigned DENOM_MID  = c_denom_mid,
    parameter int unsigned DENOM_LO   = c_denom_lo,
    parameter int unsigned STOCK_INIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_money_w-1:0] balance,
    input  logic                 bal_valid,
    input  logic                 coin_ready,
    output logic                 coin_valid,
    output logic [c_money_w-1:0] coin_out,
    output logic [c_money_w-1:0] remaining,
    output logic                 busy,
    output logic                 done,
    output logic                 short
);

    state_t                 r_state;
    logic                   w_fire;
    logic [c_money_w-1:0]   w_sel_rem;
    logic [c_money_w-1:0]   w_sel_coin;
    logic                   w_found;
    logic [2:0]             w_avail;

    assign w_fire = (r_state == S_PAY) && coin_valid && coin_ready;

    // Coin selection looks one step ahead so coin_out can be registered.
    always_comb begin
        w_sel_rem = balance;
        if (r_state == S_PAY) begin
            w_sel_rem = remaining - coin_out;
        end
    end

    if (STOCK_INIT > 15) begin : g_bad_stock_init
        $error("STOCK_INIT must fit in 4 bits");
    end

`ifdef CHANGE_STOCK_EN
    localparam logic c_stock_en = 1'b1;
    localparam logic [c_money_w-1:0] c_denoms [2:0] = '{
        c_money_w'(DENOM_HI), c_money_w'(DENOM_MID), c_money_w'(DENOM_LO)
    };

    logic [3:0] r_stock      [2:0];
    logic [3:0] w_stock_next [2:0];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_stock_next[i] = r_stock[i];
            if (w_fire && coin_out == c_denoms[i] && r_stock[i] != 4'd0) begin
                w_stock_next[i] = r_stock[i] - 4'd1;
            end
            w_avail[i] = (w_stock_next[i] != 4'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_stock[i] <= 4'(STOCK_INIT);
            end
        end else begin
            r_stock <= w_stock_next;
        end
    end
`else
    localparam logic c_stock_en = 1'b0;
    assign w_avail = 3'b111;

    if (DENOM_LO != 1) begin : g_bad_denom_lo
        $error("DENOM_LO must be 1 when supply is unlimited");
    end
`endif

    coin_select #(
        .DENOM_HI  (DENOM_HI),
        .DENOM_MID (DENOM_MID),
        .DENOM_LO  (DENOM_LO)
    ) u_coin_select (
        .amount (w_sel_rem),
        .avail  (w_avail),
        .coin   (w_sel_coin),
        .found  (w_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            coin_valid <= 1'b0;
            coin_out   <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bal_valid) begin
                        short     <= 1'b0;
                        busy      <= 1'b1;
                        remaining <= balance;
                        if (balance == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else if (w_found) begin
                            r_state    <= S_PAY;
                            coin_valid <= 1'b1;
                            coin_out   <= w_sel_coin;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            short   <= c_stock_en;
                        end
                    end
                end
                S_PAY: begin
                    if (w_fire) begin
                        remaining <= w_sel_rem;
                        if (w_sel_rem == '0 || !w_found) begin
                            r_state    <= S_DONE;
                            done       <= 1'b1;
                            coin_valid <= 1'b0;
                            coin_out   <= '0;
                            short      <= (w_sel_rem != '0) && c_stock_en;
                        end else begin
                            coin_out <= w_sel_coin;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    coin_valid <= 1'b0;
                    coin_out   <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Returns change to the customer after a vend. Accepts a balance from the vending machine core on a one-cycle valid strobe, then pays it out as a sequence of single coins to the coin hopper, largest denomination first, over a valid/ready handshake. Sits between the vending machine's balance output and the hopper driver, and signals completion so the core can return to idle.

## Interface
- DENOM_HI, default 5: largest coin value.
- DENOM_MID, default 2: middle coin value.
- DENOM_LO, default 1: smallest coin value; must be 1 when CHANGE_STOCK_EN is undefined.
- STOCK_INIT, default 8: reset coin count per denomination, 0–15; used only with CHANGE_STOCK_EN.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- balance  in  4  change amount to pay, 0–15; sampled when bal_valid is high in IDLE.
- bal_valid  in  1  one-cycle strobe: start paying balance.
- coin_ready  in  1  hopper accepts coin_out this cycle.
- coin_valid  out  1  coin_out holds a coin to release.
- coin_out  out  4  value of the offered coin.
- remaining  out  4  change still owed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when payout ends.
- short  out  1  high with done when change could not be fully paid; 0 without CHANGE_STOCK_EN.

## Operation
- States: IDLE, PAY, DONE. The encoding is a package enum.
- IDLE:
  - bal_valid=1 with balance≠0: load remaining=balance, go to PAY.
  - bal_valid=1 with balance=0: go to DONE, no coins issued.
  - bal_valid=0: stay in IDLE.
- PAY:
  - coin_valid=1.
  - coin_out = largest denomination ≤ remaining (and, with the macro, stock>0).
  - coin_out is stable while coin_valid=1 and coin_ready=0.
  - On coin_valid & coin_ready: remaining -= coin_out. If the result is 0, go to DONE.
  - If no denomination qualifies (stock case only): go to DONE with short latched.
- DONE: done=1 for one cycle, then IDLE. short is cleared on the next load.
- bal_valid outside IDLE is ignored. It is not queued.
- Arithmetic is 4-bit unsigned. Subtraction never underflows because the selected coin is always ≤ remaining.
- Greedy payout examples: 12 → 5,5,2; 9 → 5,2,2; 1 → 1.
- Reset mid-payout abandons the payout; the remaining amount is lost.

## Timing
- Reset values:
  - State IDLE.
  - coin_valid, done, short, busy all 0.
  - coin_out 0, remaining 0.
- Load latency: bal_valid sampled at edge N; coin_valid=1 and busy=1 from edge N.
- Throughput: with coin_ready held high, one coin per cycle.
- Completion: the last handshake at edge M gives done=1 after M for exactly one cycle; busy=0 after M+1.
- coin_out is 0 whenever coin_valid=0.

## Configuration
- CHANGE_STOCK_EN defined:
  - A 4-bit stock counter per denomination, reset to STOCK_INIT, decremented on each handshake of that denomination, saturating at 0.
  - Coin selection skips empty denominations.
  - When no coin fits, short=1 with done, and remaining keeps the unpaid amount until the next load.
- CHANGE_STOCK_EN undefined:
  - No counters; supply is unlimited.
  - short is tied to 0.
  - Payout always completes.

## Structure
- Shared package vm_pkg holds:
  - The state enum.
  - Default denomination constants.
  - The 4-bit money width constant.
- One combinational sub-module, coin_select, maps remaining plus the three stock-available bits to coin_out and a found flag. Without the macro, all stock-available bits are tied to 1.

## Test plan
- Reset asserted mid-PAY after the first coin of balance 12 → next cycle coin_valid=0, remaining=0, busy=0.
- balance=12, coin_ready=1 → coin_out 5,5,2 on three consecutive cycles, then done pulse, short=0, remaining=0.
- balance=9, coin_ready low for 3 cycles on the first coin → coin_out holds 5 stable, then 2,2, then done.
- balance=0 → no coin_valid; done pulses the cycle after the strobe.
- bal_valid with balance=7 during a payout of 12 → ignored; the payout finishes with 5,5,2.
- With CHANGE_STOCK_EN and STOCK_INIT=1, balance=12 → 5,2,1, then done with short=1 and remaining=4.
